// File: rtl/frame_buffer_shift_pkg.sv
// Shared codec constants for the frame buffer shift block.
// Holds the frame geometry (L_TOTAL, L_FRAME, PIT_MAX, L_INTERPOL) and the
// scratch-memory base addresses of the old_speech, old_wsp and old_exc buffers.
// State encodings are kept local to the module that uses them.
package frame_buffer_shift_pkg;

    localparam int unsigned L_TOTAL    = 240;
    localparam int unsigned L_FRAME    = 80;
    localparam int unsigned PIT_MAX    = 143;
    localparam int unsigned L_INTERPOL = 11;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WORD_W = 16;

    // Scratch-memory buffer bases; each region is large enough to hold
    // len + L_FRAME words for its segment.
    localparam logic [ADDR_W-1:0] OLD_SPEECH = 12'h000;
    localparam logic [ADDR_W-1:0] OLD_WSP    = 12'h100;
    localparam logic [ADDR_W-1:0] OLD_EXC    = 12'h200;

endpackage

// File: rtl/frame_buffer_shift.sv
// frame_buffer_shift: shifts old_speech, old_wsp and old_exc down by L_FRAME
// words in scratch memory, one segment after another, as forward copies
// dst[i] = src[i] with i ascending. The word index is advanced only through
// the shared external adder (addOutA + addOutB -> addIn).
//
// Ports:
//   clock        in   single clock, rising edge
//   reset        in   synchronous active-high reset
//   start        in   begin a shift; only looked at in INIT
//   addIn        in   [15:0] adder sum (combinational from addOutA/addOutB)
//   memIn        in   [31:0] read data, one cycle after memReadAddr
//   addOutA/B    out  [15:0] adder operands
//   memReadAddr  out  [11:0] read address
//   memWriteAddr out  [11:0] write address
//   memOut       out  [31:0] write data
//   memWriteEn   out  write strobe
//   done         out  one-cycle completion pulse
//
// Build option: FRAME_SHIFT_PIPELINE_EN adds a STREAM state that moves one
// word per cycle (read of word i+1 overlaps the write of word i). Without it
// each word takes a READ and a WRITE cycle. Memory results are identical.
module frame_buffer_shift #(
    parameter int unsigned L_FRAME    = frame_buffer_shift_pkg::L_FRAME,
    parameter int unsigned SPEECH_LEN = frame_buffer_shift_pkg::L_TOTAL
                                        - frame_buffer_shift_pkg::L_FRAME,
    parameter int unsigned WSP_LEN    = frame_buffer_shift_pkg::PIT_MAX,
    parameter int unsigned EXC_LEN    = frame_buffer_shift_pkg::PIT_MAX
                                        + frame_buffer_shift_pkg::L_INTERPOL
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] addIn,
    input  logic [31:0] memIn,
    output logic [15:0] addOutA,
    output logic [15:0] addOutB,
    output logic [11:0] memReadAddr,
    output logic [11:0] memWriteAddr,
    output logic [31:0] memOut,
    output logic        memWriteEn,
    output logic        done
);
    import frame_buffer_shift_pkg::*;

    typedef enum logic [2:0] {
        StInit   = 3'd0,
        StRead   = 3'd1,
        StWrite  = 3'd2,
        StDone   = 3'd3
`ifdef FRAME_SHIFT_PIPELINE_EN
        ,StStream = 3'd4
`endif
    } state_e;

    localparam logic [11:0] FrameOff   = 12'(L_FRAME);
    localparam logic [15:0] SpeechLenW = 16'(SPEECH_LEN);
    localparam logic [15:0] WspLenW    = 16'(WSP_LEN);
    localparam logic [15:0] ExcLenW    = 16'(EXC_LEN);

    state_e      state_q, state_d;
    logic [1:0]  seg_q, seg_d;
    logic [15:0] idx_q, idx_d;

    logic [11:0] src_addr;
    logic [11:0] dst_addr;
    logic [15:0] seg_len;

    // Segment descriptor mux.
    always_comb begin
        case (seg_q)
            2'd0: begin
                src_addr = OLD_SPEECH + FrameOff;
                dst_addr = OLD_SPEECH;
                seg_len  = SpeechLenW;
            end
            2'd1: begin
                src_addr = OLD_WSP + FrameOff;
                dst_addr = OLD_WSP;
                seg_len  = WspLenW;
            end
            default: begin
                src_addr = OLD_EXC + FrameOff;
                dst_addr = OLD_EXC;
                seg_len  = ExcLenW;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StInit;
            seg_q   <= 2'd0;
            idx_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        seg_d        = seg_q;
        idx_d        = idx_q;
        addOutA      = 16'd0;
        addOutB      = 16'd0;
        memReadAddr  = 12'd0;
        memWriteAddr = 12'd0;
        memOut       = 32'd0;
        memWriteEn   = 1'b0;
        done         = 1'b0;

        case (state_q)
            StInit: begin
                idx_d = 16'd0;
                seg_d = 2'd0;
                if (start) begin
                    state_d = StRead;
                end
            end

            StRead: begin
                if (idx_q < seg_len) begin
                    memReadAddr = src_addr + idx_q[11:0];
`ifdef FRAME_SHIFT_PIPELINE_EN
                    state_d     = StStream;
`else
                    state_d     = StWrite;
`endif
                end else if (seg_q < 2'd2) begin
                    // Segment finished (or empty): move on, stay in READ.
                    seg_d = seg_q + 2'd1;
                    idx_d = 16'd0;
                end else begin
                    state_d = StDone;
                end
            end

            StWrite: begin
                memWriteAddr = dst_addr + idx_q[11:0];
                memOut       = memIn;
                memWriteEn   = 1'b1;
                addOutA      = idx_q;
                addOutB      = 16'd1;
                idx_d        = addIn;
                state_d      = StRead;
            end

`ifdef FRAME_SHIFT_PIPELINE_EN
            StStream: begin
                memWriteAddr = dst_addr + idx_q[11:0];
                memOut       = memIn;
                memWriteEn   = 1'b1;
                addOutA      = idx_q;
                addOutB      = 16'd1;
                idx_d        = addIn;
                // addIn already holds idx+1, so it doubles as the look-ahead
                // read index and the end-of-segment test.
                if (addIn < seg_len) begin
                    memReadAddr = src_addr + addIn[11:0];
                end else if (seg_q < 2'd2) begin
                    seg_d   = seg_q + 2'd1;
                    idx_d   = 16'd0;
                    state_d = StRead;
                end else begin
                    state_d = StDone;
                end
            end
`endif

            StDone: begin
                done    = 1'b1;
                state_d = StInit;
            end

            default: begin
                state_d = StInit;
            end
        endcase
    end

endmodule

// File: tb/tb_frame_buffer_shift.sv
// Testbench for frame_buffer_shift: scratch memory and combinational adder
// models, scoreboard queues of expected writes and done cycles, and a monitor
// that checks every write strobe and done pulse against them.
module tb_frame_buffer_shift;
    import frame_buffer_shift_pkg::*;

`ifdef FRAME_SHIFT_PIPELINE_EN
    localparam int LAT = 461;
    localparam int W50 = 51;    // cycle offset of seg0 write #50
`else
    localparam int LAT = 918;
    localparam int W50 = 100;
`endif

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] addIn;
    logic [31:0] memIn;
    logic [15:0] addOutA;
    logic [15:0] addOutB;
    logic [11:0] memReadAddr;
    logic [11:0] memWriteAddr;
    logic [31:0] memOut;
    logic        memWriteEn;
    logic        done;

    frame_buffer_shift dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .addIn        (addIn),
        .memIn        (memIn),
        .addOutA      (addOutA),
        .addOutB      (addOutB),
        .memReadAddr  (memReadAddr),
        .memWriteAddr (memWriteAddr),
        .memOut       (memOut),
        .memWriteEn   (memWriteEn),
        .done         (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign addIn = addOutA + addOutB;

    logic [31:0] mem [0:4095];
    always @(posedge clock) begin
        memIn <= mem[memReadAddr];
        if (memWriteEn) mem[memWriteAddr] <= memOut;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        logic [15:0] idx;
    } wr_t;

    wr_t wr_q[$];
    int  done_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  wr_seen  = 0;
    logic done_prev = 1'b0;

    function automatic int seg_len(int s);
        return (s == 0) ? 160 : (s == 1) ? 143 : 154;
    endfunction

    function automatic logic [11:0] dst_base(int s);
        return (s == 0) ? OLD_SPEECH : (s == 1) ? OLD_WSP : OLD_EXC;
    endfunction

    // Word k of segment s after g completed shifts of a fresh preload.
    function automatic logic [31:0] model_val(int s, int k, int g);
        int kk = k;
        int gg = g;
        logic [31:0] base = (s == 0) ? 32'h0 : (s == 1) ? 32'h1000 : 32'h2000;
        while (gg > 0 && kk < seg_len(s)) begin
            kk += 80;
            gg--;
        end
        return base + 32'(kk);
    endfunction

    task automatic push_run(input int g);
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < seg_len(s); i++) begin
                wr_t e;
                e.addr = dst_base(s) + 12'(i);
                e.data = model_val(s, 80 + i, g);
                e.idx  = 16'(i);
                wr_q.push_back(e);
            end
        end
    endtask

    task automatic preload();
        for (int k = 0; k < 256; k++) begin
            mem[OLD_SPEECH + 12'(k)] = 32'(k);
            mem[OLD_WSP + 12'(k)]    = 32'h1000 + 32'(k);
            mem[OLD_EXC + 12'(k)]    = 32'h2000 + 32'(k);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        logic [31:0] any;
        any = {16'd0, addOutA | addOutB} | {20'd0, memReadAddr | memWriteAddr} | memOut
            | {30'd0, memWriteEn, done};
        check(name, any, 32'd0);
    endtask

    task automatic check_mem();
        for (int k = 0; k < 240; k++)
            check($sformatf("speech[%0d]", k), mem[OLD_SPEECH + 12'(k)],
                  (k < 160) ? 32'(k + 80) : 32'(k));
        for (int k = 0; k < 223; k++)
            check($sformatf("wsp[%0d]", k), mem[OLD_WSP + 12'(k)],
                  (k < 143) ? 32'h1050 + 32'(k) : 32'h1000 + 32'(k));
        for (int k = 0; k < 234; k++)
            check($sformatf("exc[%0d]", k), mem[OLD_EXC + 12'(k)],
                  (k < 154) ? 32'h2050 + 32'(k) : 32'h2000 + 32'(k));
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((wr_q.size() != 0 || done_q.size() != 0) && n < budget) begin
            @(negedge clock);
            n++;
        end
        n_checks++;
        if (wr_q.size() != 0 || done_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s_timeout: %0d writes and %0d done pulses outstanding, required 0",
                     name, wr_q.size(), done_q.size());
            wr_q.delete();
            done_q.delete();
        end
    endtask

    // Monitor: every write strobe and done pulse is matched against the queues.
    always @(negedge clock) begin
        if (memWriteEn) begin
            wr_seen++;
            n_checks++;
            if (wr_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_write: addr=%h data=%h, required no write",
                         memWriteAddr, memOut);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                if (memWriteAddr !== e.addr || memOut !== e.data || addOutA !== e.idx
                    || addOutB !== 16'd1) begin
                    n_errors++;
                    $display("FAIL write: addr=%h data=%h addOutA=%0d addOutB=%0d, required addr=%h data=%h addOutA=%0d addOutB=1",
                             memWriteAddr, memOut, addOutA, addOutB, e.addr, e.data, e.idx);
                end
            end
        end
        if (done) begin
            n_checks++;
            if (done_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_done: at cycle %0d, required no pulse", cyc);
            end else begin
                int exp_cyc;
                exp_cyc = done_q.pop_front();
                if (cyc != exp_cyc) begin
                    n_errors++;
                    $display("FAIL done_cycle: got %0d, required %0d", cyc, exp_cyc);
                end
            end
            n_checks++;
            if (done_prev) begin
                n_errors++;
                $display("FAIL done_width: done high on consecutive cycles, required 1 cycle");
            end
        end
        done_prev <= done;
    end

    initial begin
        int c0;
        reset = 1'b1;
        start = 1'b0;
        preload();
        repeat (3) @(negedge clock);
        check_idle_outputs("reset_outputs");
        reset = 1'b0;
        @(negedge clock);
        check_idle_outputs("idle_outputs");

        // Run 1: single start pulse, stray start mid-run must be ignored.
        c0 = cyc;
        wr_seen = 0;
        push_run(0);
        done_q.push_back(c0 + LAT);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        while (cyc < c0 + 100) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_idle(3000, "run1");
        check("run1_write_count", 32'(wr_seen), 32'd457);
        repeat (20) @(negedge clock);
        check_mem();

        // Run 2: abort by reset at seg0 write #50, then restart.
        preload();
        @(negedge clock);
        c0 = cyc;
        wr_seen = 0;
        push_run(0);
        done_q.push_back(c0 + LAT);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        while (cyc < c0 + W50) @(negedge clock);
        #1;
        reset = 1'b1;
        wr_q.delete();
        done_q.delete();
        @(negedge clock);
        check_idle_outputs("abort_outputs");
        @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        check("abort_write_count", 32'(wr_seen), 32'd50);
        check("abort_last_written", mem[OLD_SPEECH + 12'd49], 32'd129);
        check("abort_first_unwritten", mem[OLD_SPEECH + 12'd50], 32'd50);
        c0 = cyc;
        push_run(0);
        done_q.push_back(c0 + LAT);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_idle(3000, "rerun");
        repeat (5) @(negedge clock);
        check_mem();

        // Run 3: start held high -> back-to-back runs, second on shifted data.
        preload();
        @(negedge clock);
        c0 = cyc;
        wr_seen = 0;
        push_run(0);
        push_run(1);
        done_q.push_back(c0 + LAT);
        done_q.push_back(c0 + 2 * LAT + 1);
        start = 1'b1;
        while (cyc < c0 + LAT + 2) @(negedge clock);
        start = 1'b0;
        wait_idle(4000, "held");
        repeat (20) @(negedge clock);
        check("held_write_count", 32'(wr_seen), 32'd914);
        check_idle_outputs("final_outputs");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
